// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Bus-side sequencer for a small level-sensitive asynchronous RAM.
//   It accepts one request at a time over a req/busy handshake. The request
//   is either a single read, a single write, or a 4-word wrapping read burst.
//   Each beat runs through SETUP, STROBE and HOLD. The RAM address, r_w and
//   write-data pins only change on entry to SETUP, so they are stable while
//   oe is high.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req, we, burst        request strobe, write select, burst-read select
//   addr, wdata           start address and write data, sampled on accept
//   busy                  high from the first SETUP through the last HOLD
//   rdata, rvalid         registered read data, one-cycle pulse per read beat
//   done                  one-cycle pulse in the final HOLD of a transaction
//   mem_r_w, mem_oe       RAM control pins (r_w: 1 = write)
//   mem_addr, mem_wdata   RAM address and write-data pins
//   mem_rdata             RAM read data, valid while oe=1 and r_w=0
module mem_access_ctrl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 2,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              mem_r_w,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Width of the strobe down-counter. It is kept at least 1 bit wide,
  // so STROBE_CYCLES=1 still works.
  localparam int SC_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [SC_W-1:0]   strobe_cnt_reg;
  logic [1:0]        beat_reg;
  logic              burst_reg;
  logic              mem_r_w_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              last_strobe;
  logic              last_beat;

  assign last_strobe = (strobe_cnt_reg == '0);
  // A single access ends after its only beat.
  // A burst ends after beat 3.
  assign last_beat   = !burst_reg || (beat_reg == 2'd3);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  if (last_strobe) state_next = HOLD;
      HOLD:    state_next = last_beat ? IDLE : SETUP;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers: latched request, counters, RAM pins, read data
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cnt_reg <= '0;
      beat_reg       <= 2'd0;
      burst_reg      <= 1'b0;
      mem_r_w_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            // Bursts are read-only, so a burst flag on a write is dropped.
            burst_reg     <= burst & ~we;
            beat_reg      <= 2'd0;
            mem_r_w_reg   <= we;
            mem_addr_reg  <= addr;
            mem_wdata_reg <= wdata;
          end
        end
        SETUP: begin
          strobe_cnt_reg <= SC_W'(STROBE_CYCLES - 1);
        end
        STROBE: begin
          if (!last_strobe) begin
            strobe_cnt_reg <= strobe_cnt_reg - 1'b1;
          end else if (!mem_r_w_reg) begin
            // Capture at the end of the strobe.
            // The RAM output has settled for the whole oe window by then.
            rdata_reg <= mem_rdata;
          end
        end
        HOLD: begin
          if (!last_beat) begin
            // Next burst beat. The address wraps naturally
            // at the RAM depth.
            beat_reg     <= beat_reg + 2'd1;
            mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
          end else begin
            // Park r_w in read. oe is already low here.
            mem_r_w_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  // oe is decoded from the state register.
  // The asynchronous reset therefore drops it immediately.
  always_comb begin
    busy   = 1'b0;
    mem_oe = 1'b0;
    rvalid = 1'b0;
    done   = 1'b0;
    case (state_reg)
      IDLE:    ;
      SETUP:   busy = 1'b1;
      STROBE: begin
        busy   = 1'b1;
        mem_oe = 1'b1;
      end
      HOLD: begin
        busy   = 1'b1;
        rvalid = !mem_r_w_reg;
        done   = last_beat;
      end
      default: ;
    endcase
  end

  assign mem_r_w   = mem_r_w_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rdata     = rdata_reg;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus-side controller for the 4×8 asynchronous scratch RAM. It accepts single read/write requests, or 4-word read bursts, from on-chip logic over a req/busy handshake. It sequences the RAM's level-sensitive `r_w`/`oe`/`address`/`dato_w` pins with a guaranteed setup, strobe and hold phase, then returns registered read data with a one-cycle valid pulse. It sits between the project's top-level control logic and the RAM instance.

## Interface
Parameters:
- `DATA_W`, 8: data width; must equal the RAM word width.
- `ADDR_W`, 2: address width; the RAM depth is 2^ADDR_W.
- `STROBE_CYCLES`, 2: cycles `mem_oe` is held high per access; legal range is ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; accepted only while `busy`=0.
- `we`  in  1  1 = write, 0 = read; sampled on accept.
- `burst`  in  1  1 = 4-word wrapping read burst; ignored when `we`=1.
- `addr`  in  ADDR_W  start address; sampled on accept.
- `wdata`  in  DATA_W  write data; sampled on accept.
- `busy`  out  1  high from the first SETUP cycle through the last HOLD cycle.
- `rdata`  out  DATA_W  registered read data.
- `rvalid`  out  1  one-cycle pulse per read beat, coincident with HOLD.
- `done`  out  1  one-cycle pulse in the final HOLD of each transaction.
- `mem_r_w`  out  1  to RAM `r_w`; 1 = write.
- `mem_oe`  out  1  to RAM `oe`.
- `mem_addr`  out  ADDR_W  to RAM `address`.
- `mem_wdata`  out  DATA_W  to RAM `dato_w`.
- `mem_rdata`  in  DATA_W  from RAM `dato`; valid only while `mem_oe`=1 and `mem_r_w`=0.

## Operation
- State machine states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Entered on reset.
  - If `req`=1 at an edge, latch `we`, `burst & ~we`, `addr` and `wdata`; clear the beat counter; go to SETUP.
- SETUP:
  - Drive `mem_addr`, `mem_r_w` and `mem_wdata` from the latched values; `mem_oe`=0.
  - Go to STROBE and load the strobe counter with STROBE_CYCLES-1.
- STROBE:
  - `mem_oe`=1; `mem_addr`, `mem_r_w` and `mem_wdata` are held.
  - Decrement the strobe counter each cycle.
  - At the edge ending the last STROBE cycle, a read registers `mem_rdata` into `rdata`.
  - Then go to HOLD.
- HOLD:
  - `mem_oe`=0; address, r_w and wdata are still held.
  - `rvalid`=1 if the beat is a read.
  - Burst with beat<3: increment the beat counter, address becomes address+1 mod 2^ADDR_W, go to SETUP.
  - Otherwise: `done`=1, go to IDLE.
- `mem_r_w`, `mem_addr` and `mem_wdata` change only on entry to SETUP, so they are never toggled while `mem_oe`=1.
- In IDLE, `mem_r_w` returns to 0. `mem_addr` and `mem_wdata` keep their last values.
- A `req` seen while `busy`=1 is ignored; there is no queueing.
- `rdata` holds its value until the next read beat.
- Reset values: `busy`=0, `rvalid`=0, `done`=0, `mem_oe`=0, `mem_r_w`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, state IDLE.
- Assertion of `rst_n`=0 mid-transaction:
  - `mem_oe` drops immediately, asynchronously.
  - All outputs take their reset values.
  - No `done` or `rvalid` is issued for the aborted transaction.

## Timing
- Cycle c0 is the cycle in which `req`=1 and `busy`=0.
- Beat timing:
  - SETUP is c1.
  - STROBE is c2 through c(1+STROBE_CYCLES).
  - HOLD is c(2+STROBE_CYCLES).
  - IDLE resumes at c(3+STROBE_CYCLES).
- Per-beat cost is STROBE_CYCLES+2 cycles. With the default of 2, a single access is busy for 4 cycles: `done` in c4, `busy`=0 again in c5.
- A new `req` presented in c5 is accepted, giving a back-to-back throughput of one access per STROBE_CYCLES+3 cycles.
- A burst is busy for 4×(STROBE_CYCLES+2) cycles, i.e. 16 at default. HOLD of beat n is followed directly by SETUP of beat n+1, and `rvalid` pulses every STROBE_CYCLES+2 cycles.
- `done` and the final `rvalid` of a read fall in the same cycle.
- `rdata` is valid from the `rvalid` cycle onward.

## Test plan
The bench uses a behavioural model of the 4×8 level-sensitive RAM.
- Reset: hold `rst_n`=0 for 3 cycles -> every output matches its reset value; `busy`=0.
- Single write, `addr`=2, `wdata`=0xA5, default STROBE_CYCLES:
  - `mem_oe` is high exactly in c2–c3.
  - `mem_r_w`=1 and `mem_addr`=2 are stable over c1–c4.
  - `done` occurs in c4 only.
  - The model's word 2 = 0xA5.
- Single read of `addr`=2 after the above -> `rdata`=0xA5 with `rvalid` and `done` both high in c4.
- Burst read from `addr`=3 after preloading words {0x11, 0x22, 0x33, 0x44}:
  - `mem_addr` sequence is 3, 0, 1, 2.
  - `rvalid` pulses at c4, c8, c12, c16 with `rdata` 0x44, 0x11, 0x22, 0x33.
  - `done` occurs only at c16.
- `req` pulsed with `we`=1 during the STROBE of another access -> ignored; no extra `mem_oe` pulse and the RAM contents are unchanged.
- `rst_n` asserted during the STROBE cycle of a write with `wdata`=0x5A -> `mem_oe`=0 before the next clock edge; no `done` is issued; the controller accepts a new request on the first edge after reset is released.
